clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-setting controller that sequences the 24-hour HH:MM:SS clock counter.
- Freezes the counter while the user edits hours, then minutes, using debounced button pulses.
- Commits the edited time with a one-cycle load pulse.
- Abandons the edit after an inactivity timeout.
- Sits between the button debouncers and the clock counter's run-enable and parallel-load inputs.

Parameters:
TIMEOUT_S, 10, consecutive idle seconds in an edit state before the edit is discarded (1..63)

Ports:
Clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick_1hz  input  1  one-Clk pulse per second, shared with the clock counter
mode_btn  input  1  debounced one-Clk pulse: advance edit field / commit
inc_btn  input  1  debounced one-Clk pulse: increment field being edited
dec_btn  input  1  debounced one-Clk pulse: decrement field being edited
cur_hours  input  5  live counter hours, 0..23
cur_minutes  input  6  live counter minutes, 0..59
run_en  output  1  counter may advance on tick_1hz only while high
load_en  output  1  one-Clk parallel-load strobe to counter
load_hours  output  5  hours value to load
load_minutes  output  6  minutes value to load
load_seconds  output  6  seconds value to load, always 0
edit_field  output  2  0 = none, 1 = hours, 2 = minutes
blink  output  1  display blink phase for the edited field

Behaviour:
- Reset (asynchronous, reset_n low, any state): state RUN; run_en=1; load_en=0; load_hours=0; load_minutes=0; load_seconds=0; edit_field=0; blink=0; edit registers and idle counter=0.
- All outputs are registered.
- States: RUN, SET_HOUR, SET_MIN, COMMIT.
- RUN:
  - run_en=1, edit_field=0, blink=0; inc_btn and dec_btn ignored.
  - mode_btn -> SET_HOUR.
  - On the same edge, capture cur_hours/cur_minutes into edit_h/edit_m and clear the idle counter.
  - run_en goes low the cycle after the mode_btn pulse. A tick_1hz coinciding with that mode_btn cycle still advances the counter; the captured value is the pre-tick value.
- SET_HOUR:
  - run_en=0, edit_field=1.
  - inc_btn: edit_h+1, 23 wraps to 0. dec_btn: edit_h-1, 0 wraps to 23.
  - mode_btn -> SET_MIN.
- SET_MIN:
  - run_en=0, edit_field=2.
  - inc_btn: edit_m+1, 59 wraps to 0. dec_btn: edit_m-1, 0 wraps to 59.
  - mode_btn -> COMMIT.
- COMMIT (exactly one cycle):
  - load_en=1; load_hours=edit_h; load_minutes=edit_m; load_seconds=0; run_en=0; edit_field=0.
  - Then RUN unconditionally; buttons ignored.
  - load_en is high in the cycle after the mode_btn pulse sampled in SET_MIN; run_en returns to 1 the cycle after load_en.
- Input priority within one cycle: mode_btn > (inc_btn xor dec_btn). inc_btn and dec_btn together with no mode_btn -> no change. mode_btn with inc/dec -> inc/dec dropped.
- Idle counter (6 bits):
  - Active in SET_HOUR/SET_MIN only; cleared on any button pulse and on entry to an edit state.
  - Increments on tick_1hz. A button pulse and a tick in the same cycle -> cleared.
  - On reaching TIMEOUT_S -> RUN without load_en. Edit discarded; counter resumes from its frozen value.
- Blink:
  - Set to 1 on entry to SET_HOUR or SET_MIN.
  - Toggles on each tick_1hz while in an edit state.
  - Forced to 1 on any inc/dec pulse.
  - 0 in RUN and COMMIT.
- load_hours/load_minutes hold their last committed value outside COMMIT. The counter samples them only with load_en.
- Out-of-range cur_* at capture (hours>23, minutes>59) is captured as 0.
- reset_n asserted mid-edit: immediate return to reset values, no load_en emitted.

Decomposition:
- Shared package clock_pkg: state enum (RUN, SET_HOUR, SET_MIN, COMMIT); constants HOURS_MAX=23, MINUTES_MAX=59; field codes FIELD_NONE=0, FIELD_HOURS=1, FIELD_MINUTES=2. The same constants serve the counter.
- One natural sub-module: mod_updown, a wrap-around up/down value register parameterised by MAX and width, instantiated for edit_h and edit_m.

Test Plan:
- Reset with cur=13:45 then release; pulses mode, inc x3, mode, dec x2, mode -> load_en one cycle with load_hours=16, load_minutes=43, load_seconds=0; run_en=0 from cycle after first mode until cycle after load_en.
- Hour wrap: cur_hours=23; mode, inc, mode, mode -> load_hours=0. Minute wrap: cur_minutes=0; mode, mode, dec, mode -> load_minutes=59.
- Timeout (TIMEOUT_S=10): mode, then 10 ticks with no buttons -> return to RUN after 10th tick, no load_en, run_en=1. Same sequence with inc on 9th tick -> still in SET_HOUR after 10 ticks.
- Simultaneous inputs in SET_HOUR, edit_h=5: inc+dec same cycle -> edit_h stays 5. mode+inc same cycle -> SET_MIN with edit_h=5.
- Blink: in SET_MIN, 3 ticks -> blink 1,0,1,0. inc on next cycle -> blink=1. mode commit -> blink=0.
- Asynchronous reset_n pulse in SET_MIN, not clock-aligned -> all outputs at reset values immediately, run_en=1, load_en never asserted.

Source files
------------

// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM:SS clock: the time-setting controller state
// encoding, the field range limits (also used by the clock counter) and the
// edit-field codes presented to the display.
// ----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;

  localparam logic [1:0] FIELD_NONE    = 2'd0;
  localparam logic [1:0] FIELD_HOURS   = 2'd1;
  localparam logic [1:0] FIELD_MINUTES = 2'd2;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// ----------------------------------------------------------------------------
// clock_set_ctrl_if
// Bundles the controller's inputs (second tick, debounced buttons, live time)
// and its outputs toward the clock counter and display.
//   master : the environment side (debouncers, counter, display)
//   slave  : the time-setting controller
// ----------------------------------------------------------------------------
interface clock_set_ctrl_if;

  logic       tick_1hz;
  logic       mode_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;

  logic       run_en;
  logic       load_en;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    output tick_1hz, mode_btn, inc_btn, dec_btn, cur_hours, cur_minutes,
    input  run_en, load_en, load_hours, load_minutes, load_seconds,
           edit_field, blink
  );

  modport slave (
    input  tick_1hz, mode_btn, inc_btn, dec_btn, cur_hours, cur_minutes,
    output run_en, load_en, load_hours, load_minutes, load_seconds,
           edit_field, blink
  );

endinterface

// File: rtl/clock_set_ctrl_mod_updown.sv
// ----------------------------------------------------------------------------
// mod_updown
// Wrap-around up/down value register holding 0..MAX.
//   Clk, reset_n : clock, asynchronous active-low reset (value -> 0)
//   load         : capture load_val (out-of-range values capture as 0)
//   inc / dec    : step up / down with wrap; load has priority, then inc
//   value        : current value
// ----------------------------------------------------------------------------
module mod_updown #(
  parameter int MAX   = 23,
  parameter int WIDTH = 5
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= (load_val > MAX_V) ? '0 : load_val;
    end else if (inc) begin
      value <= (value == MAX_V) ? '0 : value + WIDTH'(1);
    end else if (dec) begin
      value <= (value == '0) ? MAX_V : value - WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// ----------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller for the 24-hour clock counter. A mode press freezes
// the counter and walks through hours, minutes and a one-cycle commit that
// parallel-loads the edited time (seconds = 0). An edit left idle for
// TIMEOUT_S seconds is abandoned and the counter resumes.
//   Clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave view of clock_set_ctrl_if (tick, buttons, live time in;
//             run_en, load strobe/values, edit_field, blink out)
// ----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic             Clk,
  input  logic             reset_n,
  clock_set_ctrl_if.slave  bus
);

  localparam logic [5:0] TIMEOUT_V = 6'(TIMEOUT_S);

  state_t     state;
  logic [5:0] idle_cnt;
  logic [4:0] edit_h;
  logic [5:0] edit_m;

  logic       run_en_q;
  logic       load_en_q;
  logic [4:0] load_hours_q;
  logic [5:0] load_minutes_q;
  logic [1:0] edit_field_q;
  logic       blink_q;

  logic capture;
  logic up_only;
  logic down_only;
  logic step_btn;
  logic timeout_hit;

  // Mode outranks inc/dec; inc and dec together cancel out.
  assign capture     = (state == RUN) && bus.mode_btn;
  assign up_only     = !bus.mode_btn && bus.inc_btn && !bus.dec_btn;
  assign down_only   = !bus.mode_btn && bus.dec_btn && !bus.inc_btn;
  assign step_btn    = bus.inc_btn || bus.dec_btn;
  assign timeout_hit = bus.tick_1hz && (idle_cnt + 6'd1 == TIMEOUT_V);

  mod_updown #(.MAX(HOURS_MAX), .WIDTH(5)) u_hours (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .load     (capture),
    .load_val (bus.cur_hours),
    .inc      ((state == SET_HOUR) && up_only),
    .dec      ((state == SET_HOUR) && down_only),
    .value    (edit_h)
  );

  mod_updown #(.MAX(MINUTES_MAX), .WIDTH(6)) u_minutes (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .load     (capture),
    .load_val (bus.cur_minutes),
    .inc      ((state == SET_MIN) && up_only),
    .dec      ((state == SET_MIN) && down_only),
    .value    (edit_m)
  );

  // Sequencer with registered outputs. Buttons reset the idle timer; a button
  // in the same cycle as a tick wins, so the tick neither counts nor blinks.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      idle_cnt       <= '0;
      run_en_q       <= 1'b1;
      load_en_q      <= 1'b0;
      load_hours_q   <= '0;
      load_minutes_q <= '0;
      edit_field_q   <= FIELD_NONE;
      blink_q        <= 1'b0;
    end else begin
      load_en_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.mode_btn) begin
            state        <= SET_HOUR;
            idle_cnt     <= '0;
            run_en_q     <= 1'b0;
            edit_field_q <= FIELD_HOURS;
            blink_q      <= 1'b1;
          end
        end
        SET_HOUR, SET_MIN: begin
          if (bus.mode_btn) begin
            idle_cnt <= '0;
            if (state == SET_HOUR) begin
              state        <= SET_MIN;
              edit_field_q <= FIELD_MINUTES;
              blink_q      <= 1'b1;
            end else begin
              state          <= COMMIT;
              load_en_q      <= 1'b1;
              load_hours_q   <= edit_h;
              load_minutes_q <= edit_m;
              edit_field_q   <= FIELD_NONE;
              blink_q        <= 1'b0;
            end
          end else if (step_btn) begin
            idle_cnt <= '0;
            blink_q  <= 1'b1;
          end else if (timeout_hit) begin
            state        <= RUN;
            idle_cnt     <= '0;
            run_en_q     <= 1'b1;
            edit_field_q <= FIELD_NONE;
            blink_q      <= 1'b0;
          end else if (bus.tick_1hz) begin
            idle_cnt <= idle_cnt + 6'd1;
            blink_q  <= ~blink_q;
          end
        end
        COMMIT: begin
          state    <= RUN;
          run_en_q <= 1'b1;
        end
        default: begin
          state    <= RUN;
          run_en_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.run_en       = run_en_q;
  assign bus.load_en      = load_en_q;
  assign bus.load_hours   = load_hours_q;
  assign bus.load_minutes = load_minutes_q;
  assign bus.load_seconds = 6'd0;
  assign bus.edit_field   = edit_field_q;
  assign bus.blink        = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Bench for clock_set_ctrl: directed scenarios with literal expectations plus
// randomized button/tick traffic, all cross-checked every cycle against a
// behavioural model of the time-setting rules.
// ----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int TIMEOUT = 10;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.TIMEOUT_S(TIMEOUT)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Model: phase 0 = running, 1 = editing hours, 2 = editing minutes,
  // 3 = the load cycle. Values kept as plain integers.
  int m_phase = 0;
  int m_h = 0;
  int m_m = 0;
  int m_idle = 0;
  int m_blink = 0;
  int m_lh = 0;
  int m_lm = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Advance the model on each clock edge from the inputs the DUT sees.
  always @(posedge Clk or negedge reset_n) begin : model_step
    int ph, h, m, idl, bl, lh, lm;
    if (!reset_n) begin
      m_phase <= 0; m_h <= 0; m_m <= 0; m_idle <= 0;
      m_blink <= 0; m_lh <= 0; m_lm <= 0;
    end else begin
      ph = m_phase; h = m_h; m = m_m; idl = m_idle;
      bl = m_blink; lh = m_lh; lm = m_lm;
      if (ph == 3) begin
        ph = 0;
      end else if (ph == 0) begin
        if (bus.mode_btn) begin
          ph  = 1;
          h   = (int'(bus.cur_hours) > 23) ? 0 : int'(bus.cur_hours);
          m   = (int'(bus.cur_minutes) > 59) ? 0 : int'(bus.cur_minutes);
          idl = 0;
          bl  = 1;
        end
      end else begin
        if (bus.mode_btn) begin
          idl = 0;
          if (ph == 1) begin
            ph = 2; bl = 1;
          end else begin
            ph = 3; bl = 0; lh = h; lm = m;
          end
        end else if (bus.inc_btn || bus.dec_btn) begin
          idl = 0;
          bl  = 1;
          if (bus.inc_btn && !bus.dec_btn) begin
            if (ph == 1) h = (h + 1) % 24; else m = (m + 1) % 60;
          end else if (bus.dec_btn && !bus.inc_btn) begin
            if (ph == 1) h = (h + 23) % 24; else m = (m + 59) % 60;
          end
        end else if (bus.tick_1hz) begin
          idl = idl + 1;
          if (idl == TIMEOUT) begin
            ph = 0; bl = 0; idl = 0;
          end else begin
            bl = 1 - bl;
          end
        end
      end
      m_phase <= ph; m_h <= h; m_m <= m; m_idle <= idl;
      m_blink <= bl; m_lh <= lh; m_lm <= lm;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge Clk) begin
    checkOutput("run_en", 8'(bus.run_en), 8'(m_phase == 0));
    checkOutput("load_en", 8'(bus.load_en), 8'(m_phase == 3));
    checkOutput("load_hours", 8'(bus.load_hours), 8'(m_lh));
    checkOutput("load_minutes", 8'(bus.load_minutes), 8'(m_lm));
    checkOutput("load_seconds", 8'(bus.load_seconds), 8'd0);
    checkOutput("edit_field", 8'(bus.edit_field),
                8'((m_phase == 1 || m_phase == 2) ? m_phase : 0));
    checkOutput("blink", 8'(bus.blink), 8'(m_blink));
  end

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic mode, input logic inc,
                               input logic dec, input logic tick);
    bus.mode_btn = mode;
    bus.inc_btn  = inc;
    bus.dec_btn  = dec;
    bus.tick_1hz = tick;
    @(posedge Clk);
    #1;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    bus.dec_btn  = 1'b0;
    bus.tick_1hz = 1'b0;
  endtask

  initial begin
    int rate;
    int r;
    bus.mode_btn    = 1'b0;
    bus.inc_btn     = 1'b0;
    bus.dec_btn     = 1'b0;
    bus.tick_1hz    = 1'b0;
    bus.cur_hours   = 5'd13;
    bus.cur_minutes = 6'd45;

    #12;
    checkOutput("reset run_en", 8'(bus.run_en), 8'd1);
    checkOutput("reset load_en", 8'(bus.load_en), 8'd0);
    checkOutput("reset edit_field", 8'(bus.edit_field), 8'd0);
    #11 reset_n = 1'b1;
    @(posedge Clk); #1;
    checkOutput("post-reset blink", 8'(bus.blink), 8'd0);
    checkOutput("post-reset load_hours", 8'(bus.load_hours), 8'd0);

    // 13:45 -> hours +3, minutes -2 -> 16:43
    $display("[TB] basic edit and commit");
    applyStimulus(1, 0, 0, 0);
    checkOutput("edit run_en", 8'(bus.run_en), 8'd0);
    checkOutput("edit field hours", 8'(bus.edit_field), 8'd1);
    repeat (3) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("edit field minutes", 8'(bus.edit_field), 8'd2);
    repeat (2) applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("commit load_en", 8'(bus.load_en), 8'd1);
    checkOutput("commit load_hours", 8'(bus.load_hours), 8'd16);
    checkOutput("commit load_minutes", 8'(bus.load_minutes), 8'd43);
    checkOutput("commit run_en", 8'(bus.run_en), 8'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("after commit load_en", 8'(bus.load_en), 8'd0);
    checkOutput("after commit run_en", 8'(bus.run_en), 8'd1);
    checkOutput("held load_hours", 8'(bus.load_hours), 8'd16);

    $display("[TB] wrap cases");
    bus.cur_hours = 5'd23;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("hour wrap", 8'(bus.load_hours), 8'd0);
    applyStimulus(0, 0, 0, 0);
    bus.cur_hours   = 5'd10;
    bus.cur_minutes = 6'd0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("minute wrap", 8'(bus.load_minutes), 8'd59);
    checkOutput("minute wrap hours", 8'(bus.load_hours), 8'd10);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] inactivity timeout");
    applyStimulus(1, 0, 0, 0);
    repeat (TIMEOUT - 1) applyStimulus(0, 0, 0, 1);
    checkOutput("before timeout field", 8'(bus.edit_field), 8'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("timeout field", 8'(bus.edit_field), 8'd0);
    checkOutput("timeout run_en", 8'(bus.run_en), 8'd1);
    checkOutput("timeout load_en", 8'(bus.load_en), 8'd0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    repeat (TIMEOUT - 2) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("timeout restarted", 8'(bus.edit_field), 8'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] simultaneous buttons");
    bus.cur_hours   = 5'd5;
    bus.cur_minutes = 6'd20;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("mode beats inc", 8'(bus.edit_field), 8'd2);
    applyStimulus(1, 0, 0, 0);
    checkOutput("inc+dec cancel", 8'(bus.load_hours), 8'd5);
    checkOutput("mode+inc minutes", 8'(bus.load_minutes), 8'd20);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] blink phase");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("blink entry", 8'(bus.blink), 8'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink tick1", 8'(bus.blink), 8'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink tick2", 8'(bus.blink), 8'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("blink tick3", 8'(bus.blink), 8'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("blink on inc", 8'(bus.blink), 8'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("blink commit", 8'(bus.blink), 8'd0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] asynchronous reset mid-edit");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async run_en", 8'(bus.run_en), 8'd1);
    checkOutput("async edit_field", 8'(bus.edit_field), 8'd0);
    checkOutput("async blink", 8'(bus.blink), 8'd0);
    checkOutput("async load_hours", 8'(bus.load_hours), 8'd0);
    checkOutput("async load_minutes", 8'(bus.load_minutes), 8'd0);
    repeat (2) @(posedge Clk);
    #3 reset_n = 1'b1;
    @(posedge Clk); #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("no load after reset", 8'(bus.load_en), 8'd0);
      applyStimulus(0, 0, 0, 0);
    end

    $display("[TB] randomized traffic");
    rate = 20;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) rate = ($urandom_range(0, 1) == 0) ? 2 : 20;
      bus.cur_hours   = 5'($urandom_range(0, 31));
      bus.cur_minutes = 6'($urandom_range(0, 63));
      r = int'($urandom_range(0, 99));
      applyStimulus(r < rate / 3 + 1,
                    (r >= 50) && (r < 50 + rate),
                    (r >= 50 + rate / 2) && (r < 50 + rate + rate / 2),
                    $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
